// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//
// Input-conditioning stage that sits in front of the keyed 4-to-1 selector.
// Raw board switch/button levels arrive asynchronous to clk and bounce. Each
// bit passes through a two-flop synchroniser and then an independent debounce
// counter. A bit's stable level only moves after the synchronised level has
// disagreed with it for STABLE_CYCLES consecutive clocks.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous, active-low reset; clears every flop
//   sw_raw     raw switch levels (asynchronous to clk)
//   sw_stable  debounced levels; [1:0] = selector key, [9:2] = data words X0..X3
//   sw_rise    one-cycle pulse per bit when sw_stable goes 0->1
//   sw_fall    one-cycle pulse per bit when sw_stable goes 1->0
//   changed    one-cycle pulse when any stable bit updated this cycle
//
// Every output comes straight from a flop. No combinational path runs from
// sw_raw to any output.
// -----------------------------------------------------------------------------
module sw_debounce #(
    parameter int WIDTH         = 10,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             changed
);

    // The counter reaching CNT_LAST marks the STABLE_CYCLES-th consecutive
    // cycle of disagreement. The counter is held at or below this value.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] stable_r;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;
    logic             changed_r;
    logic [CNT_W-1:0] cnt_r [WIDTH];

    logic [WIDTH-1:0] stable_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic             changed_s;
    logic [CNT_W-1:0] cnt_s [WIDTH];

    // Two-flop synchroniser per bit, with nothing between the flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {WIDTH{1'b0}};
            sync2_r <= {WIDTH{1'b0}};
        end else begin
            sync1_r <= sw_raw;
            sync2_r <= sync1_r;
        end
    end

    // Per-bit debounce decision: next counter, next stable level and edge pulses.
    always_comb begin
        stable_s  = stable_r;
        rise_s    = {WIDTH{1'b0}};
        fall_s    = {WIDTH{1'b0}};
        changed_s = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_s[i] = CNT_ZERO;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_r[i] == stable_r[i]) begin
                // Agreement drops any partial count, so an earlier short
                // glitch gives no credit to a later deviation.
                cnt_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == CNT_LAST) begin
                cnt_s[i]    = CNT_ZERO;
                stable_s[i] = sync2_r[i];
                rise_s[i]   = sync2_r[i];
                fall_s[i]   = ~sync2_r[i];
            end else begin
                cnt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
        changed_s = |(rise_s | fall_s);
    end

    // Debounce state plus registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r  <= {WIDTH{1'b0}};
            rise_r    <= {WIDTH{1'b0}};
            fall_r    <= {WIDTH{1'b0}};
            changed_r <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            stable_r  <= stable_s;
            rise_r    <= rise_s;
            fall_r    <= fall_s;
            changed_r <= changed_s;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_s[i];
            end
        end
    end

    assign sw_stable = stable_r;
    assign sw_rise   = rise_r;
    assign sw_fall   = fall_r;
    assign changed   = changed_r;

endmodule

// File: tb/tb_sw_debounce.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce
//
// The reference model works from the stable-level rule itself. It keeps a
// two-deep delay queue of raw samples to give the synchronised level seen at
// each edge. It also keeps a sliding window of the last STABLE_CYCLES of those
// levels. A bit updates when every level in the window disagrees with its
// current stable value. For every edge the model pushes the expected outputs
// into a queue. A separate monitor pops that queue 1 ns after each edge and
// compares. Directed checks cover the latency and the async-reset points.
// -----------------------------------------------------------------------------
module tb_sw_debounce;

    localparam int WIDTH = 10;
    localparam int S     = 4;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic [WIDTH-1:0] sw_raw = '0;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             changed;

    sw_debounce #(.WIDTH(WIDTH), .STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_raw    (sw_raw),
        .sw_stable (sw_stable),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .changed   (changed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] stable;
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
        logic             chg;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] samp_q[$];
    logic [WIDTH-1:0] win_q[$];
    logic [WIDTH-1:0] stable_m = '0;

    int checks = 0;
    int errors = 0;

    // Reference model: one expected output set per rising edge.
    always @(posedge clk) begin
        exp_t             e;
        logic [WIDTH-1:0] s2;
        logic [WIDTH-1:0] dev;
        e = '0;
        if (!rst_n) begin
            samp_q.delete();
            samp_q.push_back('0);
            samp_q.push_back('0);
            win_q.delete();
            stable_m = '0;
        end else begin
            s2 = samp_q.pop_front();
            samp_q.push_back(sw_raw);
            win_q.push_back(s2);
            if (win_q.size() > S) void'(win_q.pop_front());
            dev = '1;
            if (win_q.size() < S) dev = '0;
            foreach (win_q[k]) dev &= (win_q[k] ^ stable_m);
            e.rise   = dev & ~stable_m;
            e.fall   = dev & stable_m;
            stable_m = stable_m ^ dev;
            e.stable = stable_m;
            e.chg    = |dev;
        end
        exp_q.push_back(e);
    end

    // Monitor: compare DUT outputs against the scoreboard after every edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t no expected entry", $time);
        end else begin
            e = exp_q.pop_front();
            if ({sw_stable, sw_rise, sw_fall, changed} !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got stable=%h rise=%h fall=%h chg=%b required stable=%h rise=%h fall=%h chg=%b",
                         $time, sw_stable, sw_rise, sw_fall, changed,
                         e.stable, e.rise, e.fall, e.chg);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, req);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts edges (first sampling edge = 1) until the masked stable bits equal
    // target. Returns 0 if that does not happen within the budget.
    task automatic edges_until(input logic [WIDTH-1:0] mask, input logic [WIDTH-1:0] target,
                               output int n);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if ((sw_stable & mask) == target) begin
                n = k;
                break;
            end
        end
    endtask

    // Waits for a changed pulse and reports the rise/fall vectors seen with it.
    task automatic wait_change(output logic [WIDTH-1:0] r, output logic [WIDTH-1:0] f,
                               output logic seen);
        seen = 1'b0;
        r = '0;
        f = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (changed) begin
                seen = 1'b1;
                r = sw_rise;
                f = sw_fall;
                break;
            end
        end
    endtask

    initial begin
        int               n;
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] f;
        logic             seen;

        // Reset held with all raw bits high: outputs must stay 0.
        sw_raw = 10'h3FF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("reset_hold_outputs", {sw_stable, sw_rise, sw_fall, changed}, 32'h0);
        end
        rst_n = 1'b1;
        edges_until(10'h3FF, 10'h3FF, n);
        check("reset_release_latency", n, S + 2);
        check("reset_release_rise", sw_rise, 10'h3FF);
        check("reset_release_changed", changed, 1'b1);

        // Back to all-0, then a clean step on the select bits.
        @(negedge clk);
        sw_raw = '0;
        settle(12);
        sw_raw[1:0] = 2'b10;
        edges_until(10'h003, 10'h002, n);
        check("clean_step_latency", n, S + 2);
        check("clean_step_rise", sw_rise, 10'h002);
        check("clean_step_fall", sw_fall, 10'h000);
        settle(4);

        // Bounce on bit 3 with 2-cycle phases, then settle high.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            sw_raw[3] = ~k[0];
            settle(1);
            check("bounce_no_update", sw_stable[3], 1'b0);
        end
        @(negedge clk);
        sw_raw[3] = 1'b1;
        edges_until(10'h008, 10'h008, n);
        check("bounce_settle_latency", n, S + 2);
        settle(4);

        // Short 3-cycle glitch low on bit 5 once it is stably high.
        sw_raw[5] = 1'b1;
        settle(10);
        sw_raw[5] = 1'b0;
        settle(3);
        sw_raw[5] = 1'b1;
        settle(10);
        check("glitch_stable_kept", sw_stable[5], 1'b1);

        // Three bits flip together: 0 and 9 rise, 4 falls.
        sw_raw[4] = 1'b1;
        settle(10);
        sw_raw[0] = 1'b1;
        sw_raw[4] = 1'b0;
        sw_raw[9] = 1'b1;
        wait_change(r, f, seen);
        check("simul_seen", seen, 1'b1);
        check("simul_rise", r, 10'h201);
        check("simul_fall", f, 10'h010);
        @(posedge clk);
        #1;
        check("simul_changed_one_cycle", changed, 1'b0);

        // Reset between edges in the middle of a count on bit 2.
        @(negedge clk);
        sw_raw[2] = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_clear", {sw_stable, sw_rise, sw_fall, changed}, 32'h0);
        settle(3);
        rst_n = 1'b1;
        edges_until('1, sw_raw, n);
        check("midreset_full_latency", n, S + 2);
        settle(4);

        // Randomised phase: short and long holds, occasional async reset.
        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            sw_raw = sw_raw ^ WIDTH'(1 << $urandom_range(WIDTH - 1, 0));
            if ($urandom_range(3, 0) == 0)
                sw_raw = sw_raw ^ WIDTH'(1 << $urandom_range(WIDTH - 1, 0));
            if ($urandom_range(39, 0) == 0) begin
                #2;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            settle($urandom_range(8, 1) - 1);
        end
        settle(12);
        @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
